// File: rtl/branch_condition_unit_pkg.sv
// Shared constants and types for the branch condition unit.
// Optional build macro: BCU_EARLY_NT_EN (early not-taken resolve).
package branch_condition_unit_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_TGT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic       sel_res;
    logic       inv;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/branch_condition_unit_decode.sv
// Maps a branch funct3 onto ALU opcode, flag select and polarity.
// Optional build macro: none used here.
module branch_decode
  import branch_condition_unit_pkg::*;
(
  input  logic [2:0] i_funct3,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '{op: ALU_ADD, sel_res: 1'b0,
              inv: 1'b0, illegal: 1'b1};
    unique case (1'b1)
      (i_funct3 == F3_BEQ):
        o_dec = '{ALU_SUB, 1'b0, 1'b0, 1'b0};
      (i_funct3 == F3_BNE):
        o_dec = '{ALU_SUB, 1'b0, 1'b1, 1'b0};
      (i_funct3 == F3_BLT):
        o_dec = '{ALU_SLT, 1'b1, 1'b0, 1'b0};
      (i_funct3 == F3_BGE):
        o_dec = '{ALU_SLT, 1'b1, 1'b1, 1'b0};
      (i_funct3 == F3_BLTU):
        o_dec = '{ALU_SLTU, 1'b1, 1'b0, 1'b0};
      (i_funct3 == F3_BGEU):
        o_dec = '{ALU_SLTU, 1'b1, 1'b1, 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_condition_unit.sv
// Branch resolver that time-shares the execute-stage ALU.
// Optional build macro: BCU_EARLY_NT_EN (not-taken skips TGT).
module branch_condition_unit
  import branch_condition_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_funct3,
  input  logic [WIDTH-1:0]        req_rs1,
  input  logic [WIDTH-1:0]        req_rs2,
  input  logic [WIDTH-1:0]        req_pc,
  input  logic [WIDTH-1:0]        req_imm,
  output logic [2:0]              alu_operation_code,
  output logic signed [WIDTH-1:0] alu_operand_a,
  output logic signed [WIDTH-1:0] alu_operand_b,
  output logic [WIDTH-1:0]        alu_operand_a_unsign,
  output logic [WIDTH-1:0]        alu_operand_b_unsign,
  input  logic [WIDTH-1:0]        alu_result,
  input  logic                    alu_is_zero,
  input  logic                    alu_is_negative,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_taken,
  output logic [WIDTH-1:0]        resp_target,
  output logic                    resp_illegal
);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_rs1;
  logic [WIDTH-1:0] r_rs2;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_target;
  logic             r_taken;
  logic             r_illegal;

  dec_t             w_dec;
  logic             w_flag;
  logic             w_taken;
  logic             w_skip;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_unused_neg;

  branch_decode u_decode (
    .i_funct3 (r_funct3),
    .o_dec    (w_dec)
  );

  // Negative flag is carried through for future branch forms only.
  assign w_unused_neg = alu_is_negative;

  assign w_flag  = w_dec.sel_res ? alu_result[0]
                                 : alu_is_zero;
  assign w_taken = !w_dec.illegal
                && (w_flag ^ w_dec.inv);

`ifdef BCU_EARLY_NT_EN
  assign w_skip = !w_taken;
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_next             = r_state;
    alu_operation_code = ALU_ADD;
    w_op_a             = '0;
    w_op_b             = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) w_next = ST_CMP;
      end
      ST_CMP: begin
        alu_operation_code = w_dec.op;
        w_op_a = r_rs1;
        w_op_b = r_rs2;
        w_next = w_skip ? ST_RESP : ST_TGT;
      end
      ST_TGT: begin
        w_op_a = r_pc;
        w_op_b = r_imm;
        w_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign alu_operand_a        = w_op_a;
  assign alu_operand_b        = w_op_b;
  assign alu_operand_a_unsign = w_op_a;
  assign alu_operand_b_unsign = w_op_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_funct3  <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_target  <= '0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_funct3 <= req_funct3;
            r_rs1    <= req_rs1;
            r_rs2    <= req_rs2;
            r_pc     <= req_pc;
            r_imm    <= req_imm;
          end
        end
        ST_CMP: begin
          r_taken   <= w_taken;
          r_illegal <= w_dec.illegal;
          if (w_skip) r_target <= '0;
        end
        ST_TGT: begin
          r_target <= alu_result;
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign resp_valid   = (r_state == ST_RESP);
  assign resp_taken   = r_taken;
  assign resp_target  = r_target;
  assign resp_illegal = r_illegal;

endmodule

// File: doc/branch_condition_unit.md
# branch_condition_unit

Multi-cycle initiator for the shared ALU in the execute stage: accepts a conditional-branch request, sequences compare and target-address operations through ArithmeticLogicUnit, and returns a registered taken/target decision. ALU opcode, operands and flags all pass through this block, and it reuses the existing SUB/SLT/SLTU/ADD datapath instead of adding a second comparator.

## Interface
- WIDTH, 32, datapath width; matches the ALU WIDTH.
- Timing: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  branch request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- req_rs1, req_rs2  in  WIDTH  compare operands.
- req_pc, req_imm  in  WIDTH  branch base and signed offset.
- alu_operation_code  out  3  opcode to the ALU.
- alu_operand_a, alu_operand_b  out  WIDTH  signed ALU operands.
- alu_operand_a_unsign, alu_operand_b_unsign  out  WIDTH  same bits as the signed operands, used for SLTU.
- alu_result  in  WIDTH  ALU result.
- alu_is_zero, alu_is_negative  in  1  ALU flags.
- resp_valid  out  1  decision available.
- resp_ready  in  1  consumer accepts the decision.
- resp_taken  out  1  branch taken.
- resp_target  out  WIDTH  req_pc + req_imm (wrap modulo 2^WIDTH).
- resp_illegal  out  1  funct3 was 010 or 011.

## Operation
- FSM states: IDLE, CMP, TGT, RESP.
- IDLE: req_ready=1. When req_valid is high, latch funct3, rs1, rs2, pc and imm, then move to CMP.
- CMP: drive the compare op with a=rs1 and b=rs2.
  - BEQ/BNE use SUB (001); taken = alu_is_zero for BEQ, !alu_is_zero for BNE.
  - BLT/BGE use SLT (101); taken = alu_result[0] for BLT, its inverse for BGE.
  - BLTU/BGEU use SLTU (110); same polarity rule as BLT/BGE.
  - Register taken at the end of CMP, then move to TGT.
- TGT: drive ADD (000) with a=pc and b=imm. Register alu_result into resp_target, then move to RESP.
- RESP: hold resp_valid=1 and all resp_* fields stable until resp_ready is high, then return to IDLE.
- Illegal funct3 (010/011): CMP drives ADD and ignores the flags. taken=0 and resp_illegal=1. TGT still runs.
- ALU outputs in IDLE and RESP: alu_operation_code=000 and all operands 0, so the ALU never sees X or the ALU default code.
- The block never consumes alu_is_negative for decisions. The flag is routed only for future use.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_taken=0, resp_illegal=0, resp_target=0. ALU outputs are 000 and 0.
- Latency: request accepted at edge N; CMP during cycle N+1; TGT during cycle N+2; resp_valid high from cycle N+3.
- Throughput: one request per 4 cycles when resp_ready is held high. The next accept is possible on the cycle after the RESP handshake.
- req_valid outside IDLE is ignored; req_ready=0 in those states.
- rst asserted in any state returns to IDLE on the next edge. An in-flight decision is dropped and resp_valid clears with no partial response.
- The ALU is combinational, so its result is sampled in the same cycle the operands are driven. No extra wait states.

## Configuration
- BCU_EARLY_NT_EN
  - Defined: a not-taken decision (including illegal) goes CMP to RESP directly, skipping TGT. resp_target is 0 and latency is 2 cycles after accept. Taken branches are unchanged.
  - Undefined: TGT always runs, with fixed 3-cycle latency.

## Structure
- Shared package holds:
  - ALU opcode constants (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLTU 110).
  - Branch funct3 constants.
  - FSM state enum.
- One combinational sub-module, branch_decode. It maps funct3 to ALU opcode, flag select (zero/result[0]), invert bit and illegal bit.

## Test plan
- BEQ rs1=5, rs2=5, pc=0x100, imm=0x20 -> alu_operation_code=001 in CMP; resp_valid at N+3 with taken=1, target=0x120.
- BLT rs1=-1 (0xFFFFFFFF), rs2=1 -> taken=1. BLTU with the same operands -> taken=0 (early-NT build: resp at N+2, target=0).
- BGEU rs1=0x80000000, rs2=1 -> taken=1. pc=0xFFFFFFF0, imm=0x20 -> target wraps to 0x00000010.
- funct3=011 -> resp_illegal=1, taken=0. The ALU never receives code 111.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0, and a second req_valid is not accepted until one cycle after the handshake.
- Reset asserted during TGT -> next cycle IDLE, resp_valid=0, req_ready=1, and a fresh request completes normally.
